// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and state encodings for the tx/rx pair
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 10000;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter, one-cycle tick on the last cycle of each period
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter; UART_TX_PARITY_EN switches it to 8E1
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [UART_DATA_W-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic                   o_done
);

    uart_state_t            state;
    uart_state_t            state_nxt;
    logic [UART_DATA_W-1:0] shift_reg;
    logic [2:0]             bit_cnt;
    logic                   tick;
    logic                   accept;
    logic                   baud_clear;
    logic                   tx_d;
    logic                   tx_q;
    logic                   done_q;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    assign o_ready    = (state == ST_IDLE) && !i_rst;
    assign accept     = i_valid && o_ready;
    assign baud_clear = (state == ST_IDLE);

    // Held clear in IDLE so the first START period begins at count 0.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk   (clk),
        .rst   (i_rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_START;
            ST_START: if (tick) state_nxt = ST_DATA;
            ST_DATA: begin
                if (tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (tick) state_nxt = ST_STOP;
`endif
            ST_STOP:  if (tick) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // The line is registered from the current state, so it lags the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            tx_q   <= tx_d;
            done_q <= (state == ST_STOP) && tick;
            if (accept) begin
                shift_reg <= i_data;
`ifdef UART_TX_PARITY_EN
                parity_q  <= ^i_data;
`endif
            end else if (state == ST_DATA && tick) begin
                shift_reg <= {1'b0, shift_reg[UART_DATA_W-1:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = (state != ST_IDLE);
    assign o_done = done_q;

endmodule
